stress_test_checker: RTL
========================

STRESS_TEST_CHECKER -- requirements
Module: stress_test_checker

Interface
REQ-001 Parameter: WIDTH, default 16, data/LFSR width; only 16 and 32 are legal.
REQ-002 Parameter: ERR_CNT_WIDTH, default 16, width of the error counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rnd_seed  input  WIDTH  seed for the expected-data LFSR.
REQ-006 set_seed  input  1  load seed, clear counters, force IDLE.
REQ-007 start  input  1  IDLE -> CHECK request.
REQ-008 stop  input  1  CHECK -> IDLE request.
REQ-009 in_data  input  WIDTH  received data word under test.
REQ-010 in_valid  input  1  in_data valid.
REQ-011 in_ready  output  1  checker accepts a word this cycle.
REQ-012 active  output  1  high in CHECK state.
REQ-013 word_cnt  output  32  accepted words since last seed.
REQ-014 err_cnt  output  ERR_CNT_WIDTH  mismatching words since last seed.
REQ-015 error  output  1  sticky, at least one mismatch since last seed.
REQ-016 err_index  output  32  word_cnt value of the first mismatching word.
REQ-017 err_expected  output  WIDTH  expected value at the first mismatch.
REQ-018 err_received  output  WIDTH  in_data at the first mismatch.

Function
REQ-019 States: IDLE, CHECK; in_ready = active = (state == CHECK), driven directly from the state register.
REQ-020 Transfer occurs on a cycle with in_valid && in_ready.
REQ-021 LFSR next-state, WIDTH=16: out[15:1] = x[14:0]; out[0] = x[15]^x[14]^x[12]^x[3].
REQ-022 LFSR next-state, WIDTH=32: out[31:1] = x[30:0]; out[0] = x[31]^x[21]^x[1]^x[0].
REQ-023 set_seed, seed != 0: expected <= next(rnd_seed), so the first advance matches a generator that shifts on seed load.
REQ-024 set_seed, seed == 0: expected <= 1, with no shift.
REQ-025 set_seed: clear word_cnt, err_cnt, error, err_index, err_expected, err_received; state <= IDLE.
REQ-026 set_seed has priority over start, stop and any transfer in the same cycle; that transfer is neither counted nor compared.
REQ-027 IDLE with start and no set_seed: state <= CHECK next cycle.
REQ-028 CHECK with stop and no set_seed: state <= IDLE next cycle. A transfer in the same cycle is still compared and counted.
REQ-029 start in CHECK and stop in IDLE are ignored.
REQ-030 On each transfer: compare in_data with expected; expected <= next(expected); word_cnt <= word_cnt + 1, wrapping modulo 2^32.
REQ-031 Mismatch on a transfer: err_cnt increments, saturating at all-ones; error <= 1.
REQ-032 First mismatch only (error was 0): err_index <= pre-increment word_cnt; err_expected <= expected; err_received <= in_data. Later mismatches leave these fields unchanged.
REQ-033 Outputs updated by a transfer are visible on the cycle after the transfer (1-cycle latency).
REQ-034 With no transfer, expected and all counters hold their values.

Reset
REQ-035 On rst_n low, immediately and without a clock: state = IDLE, expected = 1, and word_cnt, err_cnt, error, err_index, err_expected, err_received all 0; hence in_ready = active = 0.
REQ-036 Deassertion of rst_n mid-stream loses all progress; a new set_seed/start sequence is required before checking resumes.

Verification
REQ-037 WIDTH=16, seed 0x0001, start, four words 0x0002, 0x0004, 0x0008, 0x0011 -> word_cnt=4, err_cnt=0, error=0.
REQ-038 WIDTH=16, seed 0x0000, start, words 0x0001, 0x0002 -> err_cnt=0; the second word is checked against 0x0002.
REQ-039 WIDTH=16, seed 0x0001, words 0x0002, 0x0005, 0x0008, 0x0000 -> err_cnt=2, err_index=1, err_expected=0x0004, err_received=0x0005.
REQ-040 ERR_CNT_WIDTH=2, six consecutive wrong words -> err_cnt holds at 3, word_cnt=6.
REQ-041 set_seed, start and in_valid asserted in the same cycle during CHECK -> state IDLE, all counters 0, in_ready=0 the next cycle.
REQ-042 WIDTH=32, seed 0x80000000, start, word 0x00000001, then rst_n pulsed low -> outputs equal the REQ-035 reset values while rst_n is low, before any clock edge.

Source files
------------

// File: rtl/stress_test_checker.sv
`default_nettype none
// ============================================================================
//  Module   : stress_test_checker
//  Purpose  : Compares a received word stream against an LFSR-generated
//             expected sequence. Counts accepted words and mismatches, and
//             captures index/expected/received of the first mismatch.
//  Revision : 1.0  initial release
// ============================================================================
module stress_test_checker #(
  parameter int WIDTH         = 16,  // 16 or 32 only
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rnd_seed,
  input  logic                     set_seed,
  input  logic                     start,
  input  logic                     stop,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     active,
  output logic [31:0]              word_cnt,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     error,
  output logic [31:0]              err_index,
  output logic [WIDTH-1:0]         err_expected,
  output logic [WIDTH-1:0]         err_received
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         expected_q, expected_d;
  logic [31:0]              word_cnt_q, word_cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     error_q, error_d;
  logic [31:0]              err_index_q, err_index_d;
  logic [WIDTH-1:0]         err_expected_q, err_expected_d;
  logic [WIDTH-1:0]         err_received_q, err_received_d;

  // Feedback bits for advancing the running expected value and the seed
  logic w_fb_exp;
  logic w_fb_seed;

  generate
    if (WIDTH == 32) begin : g_lfsr32
      assign w_fb_exp  = expected_q[31] ^ expected_q[21] ^ expected_q[1] ^ expected_q[0];
      assign w_fb_seed = rnd_seed[31]   ^ rnd_seed[21]   ^ rnd_seed[1]   ^ rnd_seed[0];
    end else begin : g_lfsr16
      assign w_fb_exp  = expected_q[15] ^ expected_q[14] ^ expected_q[12] ^ expected_q[3];
      assign w_fb_seed = rnd_seed[15]   ^ rnd_seed[14]   ^ rnd_seed[12]   ^ rnd_seed[3];
    end
  endgenerate

  logic [WIDTH-1:0] w_exp_next;
  logic [WIDTH-1:0] w_seed_next;
  assign w_exp_next  = {expected_q[WIDTH-2:0], w_fb_exp};
  assign w_seed_next = {rnd_seed[WIDTH-2:0], w_fb_seed};

  // Ready is a pure decode of the state register, so it never depends on inputs
  logic w_xfer;
  assign w_xfer = in_valid && (state_q == CHECK);

  // Next-state: set_seed dominates everything, otherwise state moves and transfers
  always_comb begin
    state_d        = state_q;
    expected_d     = expected_q;
    word_cnt_d     = word_cnt_q;
    err_cnt_d      = err_cnt_q;
    error_d        = error_q;
    err_index_d    = err_index_q;
    err_expected_d = err_expected_q;
    err_received_d = err_received_q;

    if (set_seed) begin
      // A zero seed would lock the LFSR, so it restarts from 1 without shifting
      expected_d     = (rnd_seed == '0) ? WIDTH'(1) : w_seed_next;
      state_d        = IDLE;
      word_cnt_d     = '0;
      err_cnt_d      = '0;
      error_d        = 1'b0;
      err_index_d    = '0;
      err_expected_d = '0;
      err_received_d = '0;
    end else begin
      if (state_q == IDLE && start) begin
        state_d = CHECK;
      end else if (state_q == CHECK && stop) begin
        state_d = IDLE;
      end

      if (w_xfer) begin
        expected_d = w_exp_next;
        word_cnt_d = word_cnt_q + 32'd1;
        if (in_data != expected_q) begin
          error_d = 1'b1;
          if (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
          end
          if (!error_q) begin
            err_index_d    = word_cnt_q;
            err_expected_d = expected_q;
            err_received_d = in_data;
          end
        end
      end
    end
  end

  // State and checker registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      expected_q     <= WIDTH'(1);
      word_cnt_q     <= '0;
      err_cnt_q      <= '0;
      error_q        <= 1'b0;
      err_index_q    <= '0;
      err_expected_q <= '0;
      err_received_q <= '0;
    end else begin
      state_q        <= state_d;
      expected_q     <= expected_d;
      word_cnt_q     <= word_cnt_d;
      err_cnt_q      <= err_cnt_d;
      error_q        <= error_d;
      err_index_q    <= err_index_d;
      err_expected_q <= err_expected_d;
      err_received_q <= err_received_d;
    end
  end

  assign in_ready     = (state_q == CHECK);
  assign active       = (state_q == CHECK);
  assign word_cnt     = word_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign error        = error_q;
  assign err_index    = err_index_q;
  assign err_expected = err_expected_q;
  assign err_received = err_received_q;

endmodule
`default_nettype wire
